// File: rtl/fir_stream_sequencer_if.sv
// rtl/fir_stream_sequencer_if.sv - bundle of config, status, BRAM and FIR stream signals for the sequencer
//
// Purpose: groups every non-clock/reset signal of fir_stream_sequencer.
//   master modport: sequencer side; slave modport: firmware/BRAM/FIR side.
// Signals:
//   cfg_start, cfg_src, cfg_dst, cfg_len     run configuration and start pulse
//   busy, done, err_timeout, out_cnt         run status
//   mem_en, mem_we, mem_addr, mem_wdata      BRAM port request
//   mem_rdata                                BRAM read data (1-cycle latency)
//   sm_tvalid, sm_tready, sm_tdata, sm_tlast stream of samples into the FIR
//   ss_tvalid, ss_tready, ss_tdata           stream of results from the FIR
interface fir_stream_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 11
);
  logic              cfg_start;
  logic [ADDR_W-1:0] cfg_src;
  logic [ADDR_W-1:0] cfg_dst;
  logic [LEN_W-1:0]  cfg_len;
  logic              busy;
  logic              done;
  logic              err_timeout;
  logic [LEN_W-1:0]  out_cnt;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              sm_tvalid;
  logic              sm_tready;
  logic [31:0]       sm_tdata;
  logic              sm_tlast;
  logic              ss_tvalid;
  logic              ss_tready;
  logic [31:0]       ss_tdata;

  modport master (
    input  cfg_start, cfg_src, cfg_dst, cfg_len, mem_rdata, sm_tready, ss_tvalid, ss_tdata,
    output busy, done, err_timeout, out_cnt, mem_en, mem_we, mem_addr, mem_wdata,
           sm_tvalid, sm_tdata, sm_tlast, ss_tready
  );

  modport slave (
    output cfg_start, cfg_src, cfg_dst, cfg_len, mem_rdata, sm_tready, ss_tvalid, ss_tdata,
    input  busy, done, err_timeout, out_cnt, mem_en, mem_we, mem_addr, mem_wdata,
           sm_tvalid, sm_tdata, sm_tlast, ss_tready
  );
endinterface

// File: rtl/fir_stream_sequencer.sv
// rtl/fir_stream_sequencer.sv - moves samples BRAM -> FIR stream and FIR results -> BRAM
//
// Purpose: on cfg_start fetches cfg_len words from cfg_src, streams them to the FIR,
//   writes every FIR result to cfg_dst, sharing one BRAM port (write-back wins).
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   fir_stream_sequencer_if.master (config, status, BRAM port, both streams)
module fir_stream_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int LEN_W   = 11,
  parameter int TIMEOUT = 1024
) (
  input logic                    clk,
  input logic                    rst,
  fir_stream_sequencer_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  rd_cnt;
  logic [LEN_W-1:0]  wr_cnt;
  logic              rd_pend;
  logic              in_v;
  logic [31:0]       in_d;
  logic              out_v;
  logic [31:0]       out_d;
  logic [TW-1:0]     idle_cnt;
  logic              done_q;
  logic              err_q;

  logic start_ok;
  logic sm_hs;
  logic ss_rdy;
  logic ss_hs;
  logic rd_issue;
  logic wr_issue;
  logic timed_out;
  logic finish;
  logic abort;

  assign start_ok  = (state == IDLE) && bus.cfg_start;
  assign sm_hs     = in_v && bus.sm_tready;
  assign ss_rdy    = (state != IDLE) && !out_v;
  assign ss_hs     = bus.ss_tvalid && ss_rdy;
  // A pending write-back holds off a new fetch, so the port is never double-booked.
  assign wr_issue  = out_v;
  assign rd_issue  = (state == RUN) && (rd_cnt < len_q) && !in_v && !rd_pend && !out_v;
  assign timed_out = (idle_cnt == TW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cfg_start) state_nxt = RUN;
      end
      RUN: begin
        if (len_q == '0) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end else if (timed_out) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if ((rd_cnt == len_q) && !in_v && !rd_pend) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_cnt == len_q) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end else if (timed_out) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      rd_pend  <= 1'b0;
      in_v     <= 1'b0;
      in_d     <= '0;
      out_v    <= 1'b0;
      out_d    <= '0;
      idle_cnt <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len_q    <= bus.cfg_len;
        src_q    <= bus.cfg_src;
        dst_q    <= bus.cfg_dst;
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        rd_pend  <= 1'b0;
        in_v     <= 1'b0;
        out_v    <= 1'b0;
        idle_cnt <= '0;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
      end else if (state != IDLE) begin
        if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
        rd_pend <= rd_issue;

        // A fetch is only issued with in_buf empty, so load and drain never coincide.
        if (rd_pend) begin
          in_v <= 1'b1;
          in_d <= bus.mem_rdata;
        end else if (sm_hs) begin
          in_v <= 1'b0;
        end

        if (wr_issue) begin
          wr_cnt <= wr_cnt + 1'b1;
          out_v  <= 1'b0;
        end
        // out_buf is empty at every capture, so wr_cnt equals results kept so far;
        // anything past len is accepted from the FIR and dropped.
        if (ss_hs && (wr_cnt < len_q)) begin
          out_v <= 1'b1;
          out_d <= bus.ss_tdata;
        end

        if (sm_hs || ss_hs) idle_cnt <= '0;
        else if (!timed_out) idle_cnt <= idle_cnt + 1'b1;

        if (finish) done_q <= 1'b1;
        if (abort)  err_q  <= 1'b1;

        // Leaving the run drops buffered data so nothing stale is presented in IDLE.
        if (state_nxt == IDLE) begin
          rd_pend <= 1'b0;
          in_v    <= 1'b0;
          out_v   <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;
  assign bus.out_cnt     = wr_cnt;
  assign bus.mem_en      = rd_issue || wr_issue;
  assign bus.mem_we      = wr_issue ? 4'hF : 4'h0;
  assign bus.mem_addr    = wr_issue ? (dst_q + ADDR_W'({wr_cnt, 2'b00}))
                                    : (src_q + ADDR_W'({rd_cnt, 2'b00}));
  assign bus.mem_wdata   = out_d;
  assign bus.sm_tvalid   = in_v;
  assign bus.sm_tdata    = in_d;
  // While in_buf holds sample k, rd_cnt is already k+1.
  assign bus.sm_tlast    = in_v && (rd_cnt == len_q);
  assign bus.ss_tready   = ss_rdy;

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb/tb_fir_stream_sequencer.sv - directed bench for fir_stream_sequencer with BRAM and FIR models
module tb_fir_stream_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fir_stream_sequencer_if #(.ADDR_W(12), .LEN_W(11)) bus ();

  fir_stream_sequencer #(.ADDR_W(12), .LEN_W(11), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] d;
    int          t;
  } fir_item_t;

  logic [31:0] mem [1024];
  fir_item_t   fq[$];
  logic [11:0] rd_addr[$];
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [32:0] sm_log[$];
  int          sm_valid_cycles;
  int          in_cnt;
  int          in_limit;
  logic        fir_in_en;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // BRAM model, FIR input acceptance and transaction logging.
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr[11:2]];
    if (rst) begin
      fq.delete();
    end else begin
      if (bus.ss_tvalid && bus.ss_tready) void'(fq.pop_front());
      if (bus.sm_tvalid && bus.sm_tready) begin
        fq.push_back('{d: bus.sm_tdata + 32'd1, t: cyc + 2});
        sm_log.push_back({bus.sm_tlast, bus.sm_tdata});
        in_cnt++;
      end
      if (bus.sm_tvalid) sm_valid_cycles++;
      if (bus.mem_en) begin
        if (bus.mem_we == 4'hF) begin
          mem[bus.mem_addr[11:2]] = bus.mem_wdata;
          wr_addr.push_back(bus.mem_addr);
          wr_data.push_back(bus.mem_wdata);
        end else begin
          rd_addr.push_back(bus.mem_addr);
        end
      end
    end
    cyc++;
  end

  // FIR output side: result becomes valid two cycles after acceptance, held until taken.
  always @(negedge clk) begin
    bus.sm_tready = fir_in_en && (in_cnt < in_limit);
    if (fq.size() > 0 && fq[0].t <= cyc) begin
      bus.ss_tvalid = 1'b1;
      bus.ss_tdata  = fq[0].d;
    end else begin
      bus.ss_tvalid = 1'b0;
      bus.ss_tdata  = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr.delete();
    wr_addr.delete();
    wr_data.delete();
    sm_log.delete();
    sm_valid_cycles = 0;
    in_cnt = 0;
  endtask

  task automatic start_run(input logic [11:0] src, input logic [11:0] dst, input logic [10:0] len);
    bus.cfg_src   = src;
    bus.cfg_dst   = dst;
    bus.cfg_len   = len;
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (bus.busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finish_in_budget"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_writes(input string tag, input logic [11:0] dst, input logic [31:0] d0, input int n);
    chk({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(n));
    for (int k = 0; k < n && k < wr_addr.size(); k++) begin
      chk($sformatf("%s_wr_addr%0d", tag, k), 32'(wr_addr[k]), 32'(dst + 12'(4 * k)));
      chk($sformatf("%s_wr_data%0d", tag, k), wr_data[k], d0 + 32'(k));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    rst           = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_src   = '0;
    bus.cfg_dst   = '0;
    bus.cfg_len   = '0;
    fir_in_en     = 1'b1;
    in_limit      = 1000;
    clear_logs();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
    chk("rst_ss_tready", 32'(bus.ss_tready), 32'd0);
    chk("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1) len=4, src 0x000 -> dst 0x100, results x+1
    clear_logs();
    start_run(12'h000, 12'h100, 11'd4);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wait_idle("t1", 200);
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_err", 32'(bus.err_timeout), 32'd0);
    chk("t1_out_cnt", 32'(bus.out_cnt), 32'd4);
    chk_writes("t1", 12'h100, 32'hA000_0001, 4);
    chk("t1_mem_word", mem[12'h10C >> 2], 32'hA000_0004);
    chk("t1_rd_count", 32'(rd_addr.size()), 32'd4);
    for (int k = 0; k < 4 && k < sm_log.size(); k++)
      chk($sformatf("t1_tlast%0d", k), 32'(sm_log[k][32]), 32'(k == 3));

    // 2) len=0: one busy cycle, done, no traffic
    clear_logs();
    start_run(12'h000, 12'h100, 11'd0);
    chk("t2_busy_high", 32'(bus.busy), 32'd1);
    chk("t2_done_cleared", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("t2_busy_low", 32'(bus.busy), 32'd0);
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_no_reads", 32'(rd_addr.size()), 32'd0);
    chk("t2_no_writes", 32'(wr_addr.size()), 32'd0);
    chk("t2_no_tvalid", 32'(sm_valid_cycles), 32'd0);

    // 3) FIR holds sm_tready low 5 cycles on the first sample
    clear_logs();
    fir_in_en = 1'b0;
    start_run(12'h010, 12'h200, 11'd3);
    for (int n = 0; n < 20 && !bus.sm_tvalid; n++) @(negedge clk);
    chk("t3_tvalid", 32'(bus.sm_tvalid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_data%0d", n), bus.sm_tdata, 32'hA000_0004);
      chk($sformatf("t3_no_read%0d", n), 32'(rd_addr.size()), 32'd1);
    end
    fir_in_en = 1'b1;
    wait_idle("t3", 200);
    chk("t3_done", 32'(bus.done), 32'd1);
    chk_writes("t3", 12'h200, 32'hA000_0005, 3);
    chk("t3_rd_count", 32'(rd_addr.size()), 32'd3);
    for (int k = 0; k < 3 && k < rd_addr.size(); k++)
      chk($sformatf("t3_rd_addr%0d", k), 32'(rd_addr[k]), 32'(12'h010 + 12'(4 * k)));

    // 4) FIR stops accepting after 2 samples -> timeout abort
    clear_logs();
    in_limit = 2;
    start_run(12'h020, 12'h300, 11'd4);
    wait_idle("t4", 200);
    chk("t4_err", 32'(bus.err_timeout), 32'd1);
    chk("t4_done", 32'(bus.done), 32'd0);
    chk("t4_out_cnt", 32'(bus.out_cnt), 32'd2);
    chk("t4_tvalid_dropped", 32'(bus.sm_tvalid), 32'd0);
    chk_writes("t4", 12'h300, 32'hA000_0009, 2);
    in_limit = 1000;

    // 5) source wraps past 0xFFF, start pulse mid-run ignored
    clear_logs();
    start_run(12'hFF8, 12'h400, 11'd4);
    chk("t5_err_cleared", 32'(bus.err_timeout), 32'd0);
    repeat (4) @(negedge clk);
    start_run(12'h100, 12'h000, 11'd1);
    chk("t5_busy_after_restart", 32'(bus.busy), 32'd1);
    wait_idle("t5", 200);
    chk("t5_done", 32'(bus.done), 32'd1);
    chk("t5_out_cnt", 32'(bus.out_cnt), 32'd4);
    chk("t5_rd_count", 32'(rd_addr.size()), 32'd4);
    if (rd_addr.size() == 4) begin
      chk("t5_rd_addr0", 32'(rd_addr[0]), 32'h0FF8);
      chk("t5_rd_addr1", 32'(rd_addr[1]), 32'h0FFC);
      chk("t5_rd_addr2", 32'(rd_addr[2]), 32'h0000);
      chk("t5_rd_addr3", 32'(rd_addr[3]), 32'h0004);
    end
    chk("t5_wr_count", 32'(wr_data.size()), 32'd4);
    if (wr_data.size() == 4) begin
      chk("t5_wr_data0", wr_data[0], 32'hA000_03FF);
      chk("t5_wr_data1", wr_data[1], 32'hA000_0400);
      chk("t5_wr_data2", wr_data[2], 32'hA000_0001);
      chk("t5_wr_data3", wr_data[3], 32'hA000_0002);
    end
    for (int k = 0; k < 4 && k < sm_log.size(); k++)
      chk($sformatf("t5_tlast%0d", k), 32'(sm_log[k][32]), 32'(k == 3));

    // 6) reset mid-RUN, then a fresh run
    clear_logs();
    start_run(12'h000, 12'h500, 11'd4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_done", 32'(bus.done), 32'd0);
    chk("t6_rst_err", 32'(bus.err_timeout), 32'd0);
    chk("t6_rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("t6_rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("t6_rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
    chk("t6_rst_ss_tready", 32'(bus.ss_tready), 32'd0);
    chk("t6_rst_out_cnt", 32'(bus.out_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    start_run(12'h000, 12'h500, 11'd4);
    wait_idle("t6", 200);
    chk("t6_done", 32'(bus.done), 32'd1);
    chk("t6_out_cnt", 32'(bus.out_cnt), 32'd4);
    chk_writes("t6", 12'h500, 32'hA000_0001, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
